// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instr_mem and fills the IF/ID register.
// Optional `FETCH_HALT_EN` adds a `halted` output and stops fetching at PC_LIMIT.
module pc_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd4
`ifdef FETCH_HALT_EN
  ,
  // First byte address past the instruction ROM; only meaningful with halting.
  parameter logic [15:0] PC_LIMIT = 16'd64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] instruction_in,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [15:0] fetch_count
`ifdef FETCH_HALT_EN
  ,
  output logic        halted
`endif
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] pc_plus;
  logic [15:0] redirect_tgt;
  logic        redirect;

`ifdef FETCH_HALT_EN
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  logic [0:0] state_q, state_d;
  assign halted = (state_q == ST_HALT);
`endif

  assign pc_plus      = pc_q + PC_STEP;
  assign redirect     = jump_en | branch_taken;
  assign redirect_tgt = jump_en ? jump_target : branch_target;

  always_comb begin
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
`ifdef FETCH_HALT_EN
    state_d       = state_q;
`endif
    if (redirect) begin
      // Redirect beats stall: the fetched-but-wrong-path instruction is squashed.
      pc_d         = redirect_tgt & 16'hFFFC;
      ifid_instr_d = 16'h0000;
      ifid_pc4_d   = 16'h0000;
      ifid_valid_d = 1'b0;
`ifdef FETCH_HALT_EN
      state_d      = ST_RUN;
`endif
    end else if (!stall) begin
`ifdef FETCH_HALT_EN
      if (state_q == ST_HALT) begin
        ifid_instr_d = 16'h0000;
        ifid_pc4_d   = 16'h0000;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_instr_d  = instruction_in;
        ifid_pc4_d    = pc_plus;
        ifid_valid_d  = 1'b1;
        fetch_count_d = fetch_count_q + 16'd1;
        // Last ROM word is still delivered; the PC parks on it afterwards.
        if (pc_plus >= PC_LIMIT) state_d = ST_HALT;
        else                     pc_d    = pc_plus;
      end
`else
      ifid_instr_d  = instruction_in;
      ifid_pc4_d    = pc_plus;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 16'd1;
      pc_d          = pc_plus;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ifid_instr_q  <= 16'h0000;
      ifid_pc4_q    <= 16'h0000;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 16'h0000;
`ifdef FETCH_HALT_EN
      state_q       <= ST_RUN;
`endif
    end else begin
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
`ifdef FETCH_HALT_EN
      state_q       <= state_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed plan plus random stall/redirect/reset traffic
// checked against a transaction-level model of the fetch stage.
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump_en;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instruction_in;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc4;
  logic        ifid_valid;
  logic [15:0] fetch_count;
`ifdef FETCH_HALT_EN
  logic        halted;
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic [15:0] rom [16];
  assign instruction_in = rom[pc[5:2]];

  pc_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jump_en(jump_en), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction_in(instruction_in), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count)
`ifdef FETCH_HALT_EN
    , .halted(halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: architectural state of the fetch stage.
  logic [15:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_halt;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [15:0] nxt;
    nxt = m_pc + 16'd4;
    if (rst) begin
      m_pc = 16'h0; m_instr = 16'h0; m_pc4 = 16'h0; m_valid = 1'b0; m_cnt = 16'h0; m_halt = 1'b0;
    end else if (jump_en || branch_taken) begin
      m_pc    = {(jump_en ? jump_target[15:2] : branch_target[15:2]), 2'b00};
      m_instr = 16'h0; m_pc4 = 16'h0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_halt) begin
      m_instr = 16'h0; m_pc4 = 16'h0; m_valid = 1'b0;
    end else begin
      m_instr = rom[m_pc[5:2]];
      m_pc4   = nxt;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 16'd1;
      if (HALT_ON && nxt >= 16'd64) m_halt = 1'b1;
      else                          m_pc   = nxt;
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pc", pc, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
    chk("fetch_count", fetch_count, m_cnt);
`ifdef FETCH_HALT_EN
    chk("halted", {15'd0, halted}, {15'd0, m_halt});
`endif
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; jump_en = 1'b0; branch_taken = 1'b0;
    jump_target = 16'h0; branch_target = 16'h0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    m_pc = 16'hx; m_instr = 16'hx; m_pc4 = 16'hx; m_cnt = 16'hx; m_valid = 1'bx; m_halt = 1'b0;
    idle_inputs();
    rst = 1'b1;
    #2;
    tick();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_cnt", fetch_count, 16'h0000);
    rst = 1'b0;

    repeat (3) tick();
    chk("seq3_pc", pc, 16'd12);
    chk("seq3_pc4", ifid_pc4, 16'd12);
    chk("seq3_instr", ifid_instr, rom[2]);
    chk("seq3_cnt", fetch_count, 16'd3);
    tick();                                   // pc = 16
    stall = 1'b1;
    repeat (2) tick();
    chk("stall_pc", pc, 16'd16);
    chk("stall_cnt", fetch_count, 16'd4);
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc, 16'd20);
    repeat (2) tick();                        // pc = 28
    jump_en = 1'b1; jump_target = 16'h0022;
    tick();
    chk("jump_pc", pc, 16'h0020);
    chk("jump_valid", {15'd0, ifid_valid}, 16'd0);
    chk("jump_cnt", fetch_count, 16'd7);
    idle_inputs();
    tick();
    chk("after_jump_instr", ifid_instr, rom[8]);

    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0004;
    jump_en = 1'b1; jump_target = 16'h0030;
    tick();
    chk("prio_pc", pc, 16'h0030);
    chk("prio_valid", {15'd0, ifid_valid}, 16'd0);
    idle_inputs();

    jump_en = 1'b1; jump_target = 16'hFFFE;
    tick();
    chk("far_pc", pc, 16'hFFFC);
    idle_inputs();
    tick();
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_pc4", ifid_pc4, 16'h0000);
    chk("wrap_valid", {15'd0, ifid_valid}, 16'd1);

`ifdef FETCH_HALT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (16) tick();
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_pc", pc, 16'd60);
    chk("halt_cnt", fetch_count, 16'd16);
    repeat (2) tick();
    chk("halt_bubble", {15'd0, ifid_valid}, 16'd0);
    chk("halt_pc_hold", pc, 16'd60);
    rst = 1'b1;
    tick();
    chk("halt_rst_pc", pc, 16'd0);
    chk("halt_rst_flag", {15'd0, halted}, 16'd0);
    chk("halt_rst_cnt", fetch_count, 16'd0);
    rst = 1'b0;
`endif

    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom_range(0, 49) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      jump_en      = ($urandom_range(0, 19) == 0);
      branch_taken = ($urandom_range(0, 13) == 0);
      jump_target   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      branch_target = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of instr_mem and directly downstream of it at the same time. It owns the 16-bit program counter, drives pc into instr_mem, and registers the returned 16-bit instruction into the IF/ID pipeline register for decode. It handles stall, branch/jump redirect with IF/ID flush, and counts retired fetches.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 4, sequential increment; instr_mem indexes words by pc[5:2].
PC_LIMIT, 16'd64, first byte address past the instruction ROM; used only by the optional halt feature.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hazard stall from decode; holds the PC and the IF/ID register.
jump_en  input  1  jr redirect request.
jump_target  input  16  jr target address.
branch_taken  input  1  beq taken redirect request.
branch_target  input  16  beq target address.
instruction_in  input  16  instruction from instr_mem for the current pc.
pc  output  16  current fetch address to instr_mem.
ifid_instr  output  16  registered instruction to decode.
ifid_pc4  output  16  registered pc+PC_STEP of the fetched instruction.
ifid_valid  output  1  ifid_instr holds a real instruction (0 = bubble).
fetch_count  output  16  number of valid instructions latched into IF/ID.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0. Reset overrides every other input. A reset asserted mid-stall or mid-redirect discards that operation.
- Fetch is combinational through instr_mem. The value on instruction_in at edge N belongs to the pc held during cycle N-1..N.
- Redirect is accepted at the edge. Priority order: rst > jump_en > branch_taken > stall > sequential.
- Redirect (jump_en, or branch_taken without jump_en):
  - pc <= target & 16'hFFFC (low two bits forced to 0).
  - IF/ID is flushed: ifid_instr=0, ifid_pc4=0, ifid_valid=0.
  - fetch_count is not incremented.
  - A redirect overrides stall in the same cycle.
- Stall without redirect: pc, ifid_*, and fetch_count all hold their values.
- Sequential (no rst, no redirect, no stall):
  - ifid_instr <= instruction_in.
  - ifid_pc4 <= pc+PC_STEP.
  - ifid_valid <= 1.
  - pc <= pc+PC_STEP.
  - fetch_count <= fetch_count+1.
- Arithmetic: all additions are 16-bit modulo. pc 16'hFFFC+4 wraps to 16'h0000. fetch_count wraps from 16'hFFFF to 0.
- Latency: an instruction at address A appears on ifid_instr exactly one edge after pc==A, provided there is no stall or redirect at that edge.
- No state machine beyond RUN/HALT (HALT exists only with the optional feature).

Optional Feature:
Macro FETCH_HALT_EN.
- Defined:
  - Adds output halted (1 bit, reset 0).
  - On a sequential edge where pc+PC_STEP >= PC_LIMIT, the instruction is latched normally, then the block enters HALT: halted=1 and pc holds its current value.
  - In HALT, each edge loads a bubble (ifid_valid=0) and fetch_count holds.
  - A redirect leaves HALT (halted=0, normal redirect behaviour). rst also clears HALT.
- Undefined: no halted port; pc runs freely and wraps.

Test Plan:
- Reset, then 3 free-running edges with instr_mem connected -> pc 0,4,8,12; ifid_pc4 4,8,12; ifid_valid 0→1; fetch_count 3; ifid_instr = rom[2] after the 3rd edge.
- At pc=16, raise stall for 2 cycles -> pc stays 16, ifid_* and fetch_count unchanged; after release, pc=20 on the next edge.
- At pc=28, pulse jump_en with jump_target=16'h0022 -> pc=16'h0020, ifid_valid=0, ifid_instr=0, fetch_count unchanged; the next edge latches rom[8].
- Same edge: stall=1, branch_taken=1, branch_target=16'h0004, jump_en=1, jump_target=16'h0030 -> pc=16'h0030 (jump wins, stall ignored), bubble in IF/ID.
- Force pc to 16'hFFFC via a jump, run 1 edge (macro undefined) -> pc=0, ifid_pc4=0, ifid_valid=1.
- FETCH_HALT_EN defined: run from reset to pc=60 and beyond -> halted=1 with pc=60 and fetch_count=16; further edges give ifid_valid=0. Then assert rst mid-halt -> pc=0, halted=0, fetch_count=0.
